// File: rtl/alu_exec_unit_pkg.sv
// Shared widths, opcode encodings and payload types for the integer execute unit.
package alu_exec_unit_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ROB_IDX_W = 4;
    localparam int unsigned OP_W      = 6;
    localparam int unsigned DEPTH     = 2;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Opcode 0 and anything above OP_BGEU are treated as unknown.
    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 6'd0,
        OP_ADD   = 6'd1,  OP_SUB   = 6'd2,  OP_AND   = 6'd3,  OP_OR    = 6'd4,
        OP_XOR   = 6'd5,  OP_SLT   = 6'd6,  OP_SLTU  = 6'd7,  OP_SLL   = 6'd8,
        OP_SRL   = 6'd9,  OP_SRA   = 6'd10, OP_ADDI  = 6'd11, OP_ANDI  = 6'd12,
        OP_ORI   = 6'd13, OP_XORI  = 6'd14, OP_SLTI  = 6'd15, OP_SLTIU = 6'd16,
        OP_SLLI  = 6'd17, OP_SRLI  = 6'd18, OP_SRAI  = 6'd19, OP_LUI   = 6'd20,
        OP_AUIPC = 6'd21, OP_JAL   = 6'd22, OP_JALR  = 6'd23, OP_BEQ   = 6'd24,
        OP_BNE   = 6'd25, OP_BLT   = 6'd26, OP_BGE   = 6'd27, OP_BLTU  = 6'd28,
        OP_BGEU  = 6'd29
    } op_e;

    typedef struct packed {
        logic [XLEN-1:0] value;
        logic            is_jump;
        logic            taken;
        logic [XLEN-1:0] target;
    } alu_result_t;

    typedef struct packed {
        alu_result_t          res;
        logic [ROB_IDX_W-1:0] rename;
    } fifo_entry_t;

    // Register-immediate forms take the immediate as their second operand.
    function automatic logic uses_imm(input logic [OP_W-1:0] op);
        return (op >= OP_ADDI) && (op <= OP_SRAI);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Pure combinational ALU / branch / jump evaluation of one issued instruction.
module alu_core
    import alu_exec_unit_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output alu_result_t     res_c
);

    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] pc_imm;
    logic [4:0]      shamt;

    // Decode the opcode into result value and control-transfer fields.
    always_comb begin
        op2    = uses_imm(op) ? imm : rs2;
        shamt  = op2[4:0];
        pc_imm = pc + imm;
        res_c  = '0;
        case (op)
            OP_ADD,  OP_ADDI:  res_c.value = rs1 + op2;
            OP_SUB:            res_c.value = rs1 - op2;
            OP_AND,  OP_ANDI:  res_c.value = rs1 & op2;
            OP_OR,   OP_ORI:   res_c.value = rs1 | op2;
            OP_XOR,  OP_XORI:  res_c.value = rs1 ^ op2;
            OP_SLT,  OP_SLTI:  res_c.value = XLEN'($signed(rs1) < $signed(op2));
            OP_SLTU, OP_SLTIU: res_c.value = XLEN'(rs1 < op2);
            OP_SLL,  OP_SLLI:  res_c.value = rs1 << shamt;
            OP_SRL,  OP_SRLI:  res_c.value = rs1 >> shamt;
            OP_SRA,  OP_SRAI:  res_c.value = XLEN'($signed(rs1) >>> shamt);
            OP_LUI:            res_c.value = imm;
            OP_AUIPC:          res_c.value = pc_imm;
            OP_JAL: begin
                res_c.value   = pc + XLEN'(4);
                res_c.is_jump = TRUE;
                res_c.taken   = TRUE;
                res_c.target  = pc_imm;
            end
            OP_JALR: begin
                res_c.value   = pc + XLEN'(4);
                res_c.is_jump = TRUE;
                res_c.taken   = TRUE;
                res_c.target  = (rs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                res_c.is_jump = TRUE;
                res_c.target  = pc_imm;
                case (op)
                    OP_BEQ:  res_c.taken = (rs1 == rs2);
                    OP_BNE:  res_c.taken = (rs1 != rs2);
                    OP_BLT:  res_c.taken = ($signed(rs1) < $signed(rs2));
                    OP_BGE:  res_c.taken = ($signed(rs1) >= $signed(rs2));
                    OP_BLTU: res_c.taken = (rs1 < rs2);
                    default: res_c.taken = (rs1 >= rs2);
                endcase
            end
            default: res_c.is_jump = FALSE;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute unit: computes results on issue, buffers them in order and hands them to the CDB.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 jump_wrong,
    input  logic                 alu_enable,
    input  logic [OP_W-1:0]      in_op,
    input  logic [XLEN-1:0]      in_rs1,
    input  logic [XLEN-1:0]      in_rs2,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [ROB_IDX_W-1:0] in_rd_rename,
    output logic                 alu_ready,
    output logic                 cdb_valid,
    input  logic                 cdb_grant,
    output logic [XLEN-1:0]      cdb_value,
    output logic [ROB_IDX_W-1:0] cdb_rename,
    output logic                 cdb_is_jump,
    output logic                 cdb_taken,
    output logic [XLEN-1:0]      cdb_target
);

    alu_result_t      core_res_c;
    fifo_entry_t      mem   [DEPTH];
    fifo_entry_t      mem_n [DEPTH];
    fifo_entry_t      head_q, head_n;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
    logic [CNT_W-1:0] count, count_n;
    logic             push_c, pop_c, flush_c;
    logic             valid_n, ready_n;

    alu_core u_core (
        .op    (in_op),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .imm   (in_imm),
        .pc    (in_pc),
        .res_c (core_res_c)
    );

    // Next FIFO state; the output register preloads the entry that will be at the head.
    always_comb begin
        flush_c  = rdy && jump_wrong;
        push_c   = rdy && !jump_wrong && alu_enable && alu_ready;
        pop_c    = rdy && !jump_wrong && cdb_valid && cdb_grant;
        mem_n    = mem;
        rd_ptr_n = rd_ptr;
        wr_ptr_n = wr_ptr;
        count_n  = count;
        head_n   = head_q;
        if (flush_c) begin
            rd_ptr_n = '0;
            wr_ptr_n = '0;
            count_n  = '0;
        end else begin
            if (push_c) begin
                mem_n[wr_ptr] = '{res: core_res_c, rename: in_rd_rename};
                wr_ptr_n      = wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_n = rd_ptr + PTR_W'(1);
            end
            count_n = count + CNT_W'(push_c) - CNT_W'(pop_c);
        end
        valid_n = (count_n != '0);
        ready_n = (count_n < CNT_W'(DEPTH));
        if (valid_n) begin
            head_n = mem_n[rd_ptr_n];
        end
    end

    // State and registered CDB outputs; rdy=0 naturally holds everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_q    <= '0;
            cdb_valid <= 1'b0;
            alu_ready <= 1'b1;
        end else begin
            mem       <= mem_n;
            rd_ptr    <= rd_ptr_n;
            wr_ptr    <= wr_ptr_n;
            count     <= count_n;
            head_q    <= head_n;
            cdb_valid <= valid_n;
            alu_ready <= ready_n;
        end
    end

    assign cdb_value   = head_q.res.value;
    assign cdb_rename  = head_q.rename;
    assign cdb_is_jump = head_q.res.is_jump;
    assign cdb_taken   = head_q.res.taken;
    assign cdb_target  = head_q.res.target;

endmodule
